// File: rtl/stream_mux_rr.sv
// N-channel valid/ready mux with fixed-select or round-robin arbitration into one output register.
// Latency: 1 cycle from input handshake to out_valid; one word per cycle when out_ready stays high.
// Backpressure: out_valid && !out_ready freezes the output word and arbiter state; all in_ready drop.
module stream_mux_rr #(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      control,
  input  logic                 rr_en,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] ch_data [N];
  logic [SELW-1:0]  last_grant;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic             load_en;
  logic             xfer;

  // Unflatten the channel bus so the selected word is a simple array read.
  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // The output register can take a word when empty or being drained this cycle.
  assign load_en = !out_valid || out_ready;
  assign xfer    = load_en && grant_valid;

  // Grant selection: explicit code in fixed mode, first requester after last_grant in round-robin.
  always_comb begin
    logic [SELW-1:0] idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    if (!rr_en) begin
      // Out-of-range codes (non-power-of-2 N) never grant.
      if (int'(control) < N) begin
        if (in_valid[control]) begin
          grant       = control;
          grant_valid = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = SELW'((int'(last_grant) + k) % N);
        if (!grant_valid && in_valid[idx]) begin
          grant       = idx;
          grant_valid = 1'b1;
        end
      end
    end
  end

  // At most one ready bit: only the granted channel, and only when the output can load.
  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant] = 1'b1;
  end

  // Output stage and arbiter history; a held word is only replaced by a new handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      last_grant <= SELW'(N-1);
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_data   <= ch_data[grant];
      out_sel    <= grant;
      last_grant <= grant;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (N=8, WIDTH=16).
// Inputs change 1 time unit after the rising edge; checks run on the falling edge.
// A reference model predicts grants and pushes expected words into a scoreboard queue.
module tb_stream_mux_rr;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  control;
  logic           rr_en;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_valid;
  logic           out_ready;

  stream_mux_rr #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .control(control), .rr_en(rr_en),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [W-1:0]  d;
  } exp_t;

  logic [W-1:0]  dat [N];
  exp_t          q[$];
  logic [SW-1:0] seen[$];
  logic          m_valid;
  logic [SW-1:0] m_last;
  int            errs   = 0;
  int            checks = 0;

  always_comb begin
    for (int i = 0; i < N; i++) in_data[i*W +: W] = dat[i];
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference grant: fixed code, or first valid channel scanning upward from m_last+1 with wrap.
  task automatic model_grant(output logic ok, output logic [SW-1:0] g);
    logic [SW-1:0] c;
    ok = 1'b0;
    g  = '0;
    if (!rr_en) begin
      if (in_valid[control]) begin
        ok = 1'b1;
        g  = control;
      end
    end else begin
      c = m_last;
      for (int k = 0; k < N; k++) begin
        c = (c == SW'(N-1)) ? '0 : c + 1'b1;
        if (!ok && in_valid[c]) begin
          ok = 1'b1;
          g  = c;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_last  = SW'(N-1);
    q.delete();
  endtask

  // One clock cycle: check against the model, advance the model, return just after the rising edge.
  task automatic cycle();
    logic          ok;
    logic [SW-1:0] g;
    logic [N-1:0]  exp_rdy;
    logic          ld;
    logic          nxt_valid;
    exp_t          h;
    @(negedge clk);
    model_grant(ok, g);
    ld        = !m_valid || out_ready;
    exp_rdy   = '0;
    if (ld && ok) exp_rdy[g] = 1'b1;
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    nxt_valid = m_valid;
    if (m_valid) begin
      if (q.size() == 0) begin
        check_eq("sb_empty", 32'(q.size()), 32'd1);
      end else begin
        h = q[0];
        check_eq("out_data", 32'(out_data), 32'(h.d));
        check_eq("out_sel", 32'(out_sel), 32'(h.sel));
        if (out_ready) begin
          void'(q.pop_front());
          seen.push_back(h.sel);
          nxt_valid = 1'b0;
        end
      end
    end
    if (ld && ok) begin
      h.sel = g;
      h.d   = dat[g];
      q.push_back(h);
      m_last    = g;
      nxt_valid = 1'b1;
    end
    @(posedge clk);
    m_valid = nxt_valid;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen.delete();
  endtask

  task automatic check_seen(input string tag, input int n, input logic [SW-1:0] e [16]);
    check_eq({tag, "_count"}, 32'(seen.size()), 32'(n));
    for (int i = 0; i < n && i < seen.size(); i++) check_eq(tag, 32'(seen[i]), 32'(e[i]));
  endtask

  initial begin
    logic [SW-1:0] e [16];
    rst_n = 1'b0; rr_en = 1'b0; control = '0; in_valid = '0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) dat[i] = W'(i);
    model_reset();
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_sel", 32'(out_sel), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fixed sweep: control 0..7, each word appears one cycle later.
    in_valid = '1;
    seen.delete();
    for (int c = 0; c < N; c++) begin
      control = SW'(c);
      cycle();
    end
    cycle();
    for (int i = 0; i < N; i++) e[i] = SW'(i);
    check_seen("fixed_seq", 8, e);

    // Round-robin fairness from reset: 0..7,0,1.
    do_reset();
    rr_en = 1'b1;
    in_valid = '1;
    repeat (11) cycle();
    for (int i = 0; i < 10; i++) e[i] = SW'(i % N);
    check_seen("rr_seq", 10, e);

    // Sparse round-robin with wrap past channel 7.
    do_reset();
    in_valid = 8'b0100_0100;
    repeat (5) cycle();
    e[0] = 3'd2; e[1] = 3'd6; e[2] = 3'd2; e[3] = 3'd6;
    check_seen("rr_sparse", 4, e);

    // Backpressure: load ch0, stall 3 cycles, release.
    do_reset();
    in_valid = '1;
    cycle();
    out_ready = 1'b0;
    repeat (3) cycle();
    out_ready = 1'b1;
    repeat (2) cycle();
    e[0] = 3'd0; e[1] = 3'd1;
    check_seen("bp_seq", 2, e);

    // Fixed select of an idle channel: nothing granted, output drains.
    rr_en = 1'b0;
    control = 3'd5;
    in_valid = ~8'h20;
    repeat (3) cycle();
    check_eq("idle_drain", 32'(out_valid), 32'd0);
    in_valid[5] = 1'b1;
    seen.delete();
    repeat (2) cycle();
    check_eq("ch5_seen_count", 32'(seen.size()), 32'd1);
    if (seen.size() > 0) check_eq("ch5_sel", 32'(seen[0]), 32'd5);

    // Asynchronous reset between edges while a word is held.
    rr_en = 1'b1;
    in_valid = '1;
    for (int i = 0; i < N; i++) dat[i] = W'($urandom);
    repeat (3) cycle();
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_out_data", 32'(out_data), 32'd0);
    check_eq("arst_out_sel", 32'(out_sel), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen.delete();
    repeat (3) cycle();
    e[0] = 3'd0; e[1] = 3'd1;
    check_seen("post_rst_rr", 2, e);

    // Random mix of modes, requests, select codes and consumer stalls.
    for (int t = 0; t < 300; t++) begin
      rr_en     = 1'($urandom_range(0, 1));
      control   = SW'($urandom_range(0, N-1));
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) dat[i] = W'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
